// File: rtl/gpr_wb_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gpr_wb_sched
//
// Write-back scheduler and busy scoreboard for the general-purpose register
// file. Two producers (ALU on port A, LSU on port B) share the single GPR
// write port through a round-robin arbiter. The winner's address and data are
// registered and presented to the GPR one cycle after the grant. A
// per-register busy bit is set when decode issues an instruction with a GPR
// destination and cleared on the cycle the GPR is actually written. Decode
// reads three hazard flags from that scoreboard.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   a_vld_i/a_rdy_o            ALU write-back handshake
//   a_addr_i/a_data_i          ALU destination register and result
//   b_vld_i/b_rdy_o            LSU write-back handshake
//   b_addr_i/b_data_i          LSU destination register and load data
//   iss_en_i/iss_addr_i        issue of a GPR destination (marks busy)
//   rs0_i/rs1_i/rs2_i          decode source register addresses
//   haz0_o/haz1_o/haz2_o       source register has a pending write
//   gpr_wr_o/gpr_waddr_o/
//   gpr_wd_o                   registered GPR write port
//   busy_vec_o                 full scoreboard, for debug/verification
// ---------------------------------------------------------------------------
module gpr_wb_sched #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_vld_i,
    output logic              a_rdy_o,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,

    input  logic              b_vld_i,
    output logic              b_rdy_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,

    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_addr_i,

    input  logic [ADDR_W-1:0] rs0_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              haz0_o,
    output logic              haz1_o,
    output logic              haz2_o,

    output logic              gpr_wr_o,
    output logic [ADDR_W-1:0] gpr_waddr_o,
    output logic [DATA_W-1:0] gpr_wd_o,

    output logic [NREG-1:0]   busy_vec_o
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

    gnt_e              gnt;

    // prio_b_q=1 means A won the last grant, so B is favoured on contention.
    logic              prio_b_q, prio_b_d;

    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic [NREG-1:0]   busy_q, busy_d;

    // -----------------------------------------------------------------------
    // Arbitration. A requester's rdy is a function of its own vld, so it is
    // never asserted on a cycle where that requester is idle. Gating with
    // rst_n keeps both rdy outputs low while the block is held in reset.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        gnt = GNT_NONE;
        if (rst_n) begin
            if (a_vld_i && b_vld_i) begin
                gnt = prio_b_q ? GNT_B : GNT_A;
            end else if (a_vld_i) begin
                gnt = GNT_A;
            end else if (b_vld_i) begin
                gnt = GNT_B;
            end
        end
    end

    assign a_rdy_o = (gnt == GNT_A);
    assign b_rdy_o = (gnt == GNT_B);

    // Pointer moves only on a grant; an idle cycle keeps the current favour.
    always_comb begin
        prio_b_d = prio_b_q;
        case (gnt)
            GNT_A:   prio_b_d = 1'b1;
            GNT_B:   prio_b_d = 1'b0;
            default: prio_b_d = prio_b_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write port. The winner's address/data are captured at the grant edge
    // and the GPR captures them on the following edge. With no grant the
    // enable drops while address and data hold their last values.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wd_d    = wd_q;
        case (gnt)
            GNT_A: begin
                wr_d    = 1'b1;
                waddr_d = a_addr_i;
                wd_d    = a_data_i;
            end
            GNT_B: begin
                wr_d    = 1'b1;
                waddr_d = b_addr_i;
                wd_d    = b_data_i;
            end
            default: begin
                wr_d    = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Scoreboard. The clear uses the registered write port, so a register
    // stays busy until the edge at which the GPR really captures it. The set
    // is applied after the clear: when both hit the same register at the
    // same edge a newer producer is pending and the bit must remain 1.
    // Setting an already-busy register is idempotent (no counting).
    // -----------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (wr_q && (waddr_q == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (iss_en_i && (iss_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // Hazards read the registered scoreboard only; a write on gpr_wr_o in
    // the same cycle is not bypassed.
    assign haz0_o = busy_q[rs0_i];
    assign haz1_o = busy_q[rs1_i];
    assign haz2_o = busy_q[rs2_i];

    // -----------------------------------------------------------------------
    // State registers. An asynchronous reset discards any write captured but
    // not yet delivered, so no GPR write follows a reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wd_q     <= '0;
            // NOTE: the scoreboard is reset even though it looks like a small
            // memory; stale busy bits after reset would stall decode forever.
            busy_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its next-state value from the same edge.
            prio_b_q <= prio_b_d;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
        end
    end

    assign gpr_wr_o    = wr_q;
    assign gpr_waddr_o = waddr_q;
    assign gpr_wd_o    = wd_q;
    assign busy_vec_o  = busy_q;

endmodule

// File: tb/tb_gpr_wb_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gpr_wb_sched
//
// Directed scenarios followed by randomized traffic, with every cycle checked
// against a behavioural reference model of the arbiter, write port and
// scoreboard.
// ---------------------------------------------------------------------------
module tb_gpr_wb_sched;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_vld, a_rdy, b_vld, b_rdy;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr, rs0, rs1, rs2;
    logic              haz0, haz1, haz2;
    logic              gpr_wr;
    logic [ADDR_W-1:0] gpr_waddr;
    logic [DATA_W-1:0] gpr_wd;
    logic [NREG-1:0]   busy_vec;

    always #5 clk = ~clk;

    gpr_wb_sched #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_vld_i     (a_vld),
        .a_rdy_o     (a_rdy),
        .a_addr_i    (a_addr),
        .a_data_i    (a_data),
        .b_vld_i     (b_vld),
        .b_rdy_o     (b_rdy),
        .b_addr_i    (b_addr),
        .b_data_i    (b_data),
        .iss_en_i    (iss_en),
        .iss_addr_i  (iss_addr),
        .rs0_i       (rs0),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .haz0_o      (haz0),
        .haz1_o      (haz1),
        .haz2_o      (haz2),
        .gpr_wr_o    (gpr_wr),
        .gpr_waddr_o (gpr_waddr),
        .gpr_wd_o    (gpr_wd),
        .busy_vec_o  (busy_vec)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who won last, the pending write, and a busy bit per
    // register. m_win: 0 = no grant, 1 = A, 2 = B.
    int                m_win;
    bit                m_fav_b;
    logic              m_wr;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wd;
    logic [NREG-1:0]   m_busy;

    task automatic model_reset();
        m_fav_b = 1'b0;
        m_wr    = 1'b0;
        m_waddr = '0;
        m_wd    = '0;
        m_busy  = '0;
    endtask

    // Called at a falling edge with inputs already driven: checks all DUT
    // outputs for the current cycle, advances the model across the rising
    // edge and returns at the next falling edge.
    task automatic cycle();
        #1;
        if (!rst_n)                 m_win = 0;
        else if (a_vld && b_vld)    m_win = m_fav_b ? 2 : 1;
        else if (a_vld)             m_win = 1;
        else if (b_vld)             m_win = 2;
        else                        m_win = 0;

        check("a_rdy",     a_rdy,     m_win == 1);
        check("b_rdy",     b_rdy,     m_win == 2);
        check("gpr_wr",    gpr_wr,    m_wr);
        check("gpr_waddr", gpr_waddr, m_waddr);
        check("gpr_wd",    gpr_wd,    m_wd);
        check("busy_vec",  busy_vec,  m_busy);
        check("haz0",      haz0,      m_busy[rs0]);
        check("haz1",      haz1,      m_busy[rs1]);
        check("haz2",      haz2,      m_busy[rs2]);

        @(posedge clk);
        if (rst_n) begin
            if (m_wr)   m_busy[m_waddr]  = 1'b0;
            if (iss_en) m_busy[iss_addr] = 1'b1;
            m_wr = (m_win != 0);
            if (m_win == 1) begin
                m_waddr = a_addr;
                m_wd    = a_data;
                m_fav_b = 1'b1;
            end else if (m_win == 2) begin
                m_waddr = b_addr;
                m_wd    = b_data;
                m_fav_b = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_vld = 1'b0; b_vld = 1'b0; iss_en = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        a_vld  = 1'b1; a_addr = 5'd9;  a_data = 32'h1111_0009;
        b_vld  = 1'b1; b_addr = 5'd10; b_data = 32'h2222_000A;
        iss_en = 1'b0; iss_addr = '0;
        rs0 = '0; rs1 = '0; rs2 = '0;
        model_reset();

        // Reset with both requesters valid.
        @(negedge clk);
        @(negedge clk);
        check("rst_a_rdy",  a_rdy,    1'b0);
        check("rst_b_rdy",  b_rdy,    1'b0);
        check("rst_gpr_wr", gpr_wr,   1'b0);
        check("rst_busy",   busy_vec, 32'h0);

        // Release: the first grant goes to A.
        rst_n = 1'b1;
        #1;
        check("rel_a_rdy", a_rdy, 1'b1);
        cycle();
        check("rel_waddr", gpr_waddr, 5'd9);

        // Single A write.
        idle_inputs();
        a_vld = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        check("t2_a_rdy", a_rdy, 1'b1);
        cycle();
        idle_inputs();
        #1;
        check("t2_wr",    gpr_wr,    1'b1);
        check("t2_waddr", gpr_waddr, 5'd5);
        check("t2_wd",    gpr_wd,    32'hDEAD_BEEF);
        cycle();
        check("t2_wr_off", gpr_wr,   1'b0);
        check("t2_hold",   gpr_waddr, 5'd5);

        // B alone, so that A is favoured going into contention.
        b_vld = 1'b1; b_addr = 5'd2; b_data = 32'hB0B0_0002;
        cycle();
        idle_inputs();

        // Contention: grants alternate A,B,A,B at full throughput.
        a_vld = 1'b1; a_addr = 5'd1; a_data = 32'hA000_0001;
        b_vld = 1'b1; b_addr = 5'd2; b_data = 32'hB000_0002;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_a_rdy", a_rdy, (k % 2) == 0);
            cycle();
            check("t3_wr",    gpr_wr,    1'b1);
            check("t3_waddr", gpr_waddr, (k % 2 == 0) ? 5'd1 : 5'd2);
        end
        idle_inputs();
        cycle();

        // Scoreboard: issue r7, then B writes r7.
        rs0 = 5'd7;
        iss_en = 1'b1; iss_addr = 5'd7;
        #1;
        check("t4_haz0_pre", haz0, 1'b0);
        cycle();
        iss_en = 1'b0;
        #1;
        check("t4_haz0_set", haz0, 1'b1);
        b_vld = 1'b1; b_addr = 5'd7; b_data = 32'h7777_7777;
        cycle();
        b_vld = 1'b0;
        #1;
        check("t4_wr7",       gpr_waddr, 5'd7);
        check("t4_haz0_hold", haz0,      1'b1);
        cycle();
        check("t4_haz0_clr", haz0, 1'b0);

        // Set and clear of r3 at the same edge: set wins.
        a_vld = 1'b1; a_addr = 5'd3; a_data = 32'h3333_3333;
        cycle();
        a_vld = 1'b0;
        iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        check("t5_wr3", gpr_waddr, 5'd3);
        cycle();
        iss_en = 1'b0;
        #1;
        check("t5_busy3", busy_vec[3], 1'b1);
        cycle();

        // Mid-op reset after a B grant.
        b_vld = 1'b1; b_addr = 5'd12; b_data = 32'hC0C0_000C;
        iss_en = 1'b1; iss_addr = 5'd12;
        cycle();
        iss_en = 1'b0;
        #1;
        check("t6_wr_pre", gpr_wr, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_wr",    gpr_wr,   1'b0);
        check("t6_busy",  busy_vec, 32'h0);
        check("t6_b_rdy", b_rdy,    1'b0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        cycle();

        // Randomized traffic. Addresses drawn from a small range so that
        // collisions between issue, write-back and sources are frequent.
        for (int n = 0; n < 500; n++) begin
            if (!a_vld && $urandom_range(2) != 0) begin
                a_vld  = 1'b1;
                a_addr = ADDR_W'($urandom_range(7));
                a_data = $urandom;
            end
            if (!b_vld && $urandom_range(2) != 0) begin
                b_vld  = 1'b1;
                b_addr = ADDR_W'($urandom_range(7));
                b_data = $urandom;
            end
            iss_en   = ($urandom_range(3) == 0);
            iss_addr = ADDR_W'($urandom_range(7));
            rs0      = ADDR_W'($urandom_range(7));
            rs1      = ADDR_W'($urandom_range(7));
            rs2      = ADDR_W'($urandom_range(NREG - 1));
            cycle();
            if (m_win == 1) a_vld = 1'b0;
            if (m_win == 2) b_vld = 1'b0;
        end
        idle_inputs();
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
